// File: rtl/cnt_pkg.sv
// Shared types for the limit counter: FSM state encoding and count-mode constants.
package cnt_pkg;

  typedef enum logic [1:0] {
    CNT_IDLE = 2'd0,
    CNT_RUN  = 2'd1,
    CNT_DONE = 2'd2
  } cnt_state_t;

  localparam logic MODE_WRAP    = 1'b0;
  localparam logic MODE_ONESHOT = 1'b1;

endpackage

// File: rtl/cnt_lmt_n_if.sv
// Control/status bundle of the limit counter; master drives commands, slave returns count and flags.
interface cnt_lmt_n_if #(
  parameter int WIDTH = 4
);
  logic             load;
  logic [WIDTH-1:0] data;
  logic [WIDTH-1:0] lmt;
  logic             mode;
  logic             up;
  logic             en;
  logic [WIDTH-1:0] out;
  logic             tc;
  logic             wrap;
  logic             done;
  logic             busy;

  modport master (
    output load, data, lmt, mode, up, en,
    input  out, tc, wrap, done, busy
  );

  modport slave (
    input  load, data, lmt, mode, up, en,
    output out, tc, wrap, done, busy
  );
endinterface

// File: rtl/cnt_step.sv
// Combinational modulo-2^WIDTH increment/decrement of the current count.
module cnt_step #(
  parameter int WIDTH = 4
) (
  input  logic [WIDTH-1:0] i_val,
  input  logic             i_up,
  output logic [WIDTH-1:0] o_nxt
);

  assign o_nxt = i_up ? i_val + 1'b1 : i_val - 1'b1;

endmodule

// File: rtl/cnt_lmt_n.sv
// Loadable up/down counter with latched limit, wrap/one-shot modes and an IDLE/RUN/DONE FSM.
// All flags decode from registers only; no input reaches an output combinationally.
module cnt_lmt_n
  import cnt_pkg::*;
#(
  parameter int               WIDTH     = 4,
  parameter logic [WIDTH-1:0] RESET_VAL = '0
) (
  input  logic        clk,
  input  logic        reset,
  cnt_lmt_n_if.slave  bus
);

  cnt_state_t       r_state;
  logic [WIDTH-1:0] r_out;
  logic [WIDTH-1:0] r_data_q;
  logic [WIDTH-1:0] r_lmt_q;
  logic             r_mode_q;
  logic             r_wrap;

  logic [WIDTH-1:0] w_nxt;
  logic             w_at_lmt;

  cnt_step #(.WIDTH(WIDTH)) u_step (
    .i_val (r_out),
    .i_up  (bus.up),
    .o_nxt (w_nxt)
  );

  assign w_at_lmt = (r_out == r_lmt_q);

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state  <= CNT_IDLE;
      r_out    <= RESET_VAL;
      r_data_q <= '0;
      r_lmt_q  <= '0;
      r_mode_q <= MODE_WRAP;
      r_wrap   <= 1'b0;
    end else if (bus.load) begin
      r_out    <= bus.data;
      r_data_q <= bus.data;
      r_lmt_q  <= bus.lmt;
      r_mode_q <= bus.mode;
      r_wrap   <= 1'b0;
      r_state  <= (bus.mode == MODE_ONESHOT && bus.data == bus.lmt) ? CNT_DONE : CNT_RUN;
    end else begin
      r_wrap <= 1'b0;
      if (r_state == CNT_RUN && bus.en) begin
        if (w_at_lmt) begin
          // Only a limit match reloads; plain roll-over goes through the stepper below.
          if (r_mode_q == MODE_ONESHOT) begin
            r_state <= CNT_DONE;
          end else begin
            r_out  <= r_data_q;
            r_wrap <= 1'b1;
          end
        end else begin
          r_out <= w_nxt;
          if (r_mode_q == MODE_ONESHOT && w_nxt == r_lmt_q) begin
            r_state <= CNT_DONE;
          end
        end
      end
    end
  end

  assign bus.out  = r_out;
  assign bus.tc   = (r_state != CNT_IDLE) && w_at_lmt;
  assign bus.wrap = r_wrap;
  assign bus.done = (r_state == CNT_DONE);
  assign bus.busy = (r_state == CNT_RUN);

endmodule

// File: tb/tb_cnt_lmt_n.sv
// Bench for cnt_lmt_n: directed scenarios with literal expectations plus a random run against a reference model.
module tb_cnt_lmt_n;
  localparam int W   = 4;
  localparam int MOD = 1 << W;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  cnt_lmt_n_if #(.WIDTH(W)) bus ();

  cnt_lmt_n #(.WIDTH(W), .RESET_VAL(4'd0)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  int tests = 0;
  int fails = 0;

  // Reference model: count, latched settings, and whether the counter is running / finished.
  int m_out, m_dq, m_lq;
  bit m_mode, m_run, m_done, m_wrap;
  bit cmp_on = 1'b0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0d, expected %0d at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic model_edge(input bit rst, input bit ld, input int d, input int l,
                            input bit md, input bit u, input bit e);
    if (rst) begin
      m_out = 0; m_dq = 0; m_lq = 0; m_mode = 0;
      m_run = 0; m_done = 0; m_wrap = 0;
    end else if (ld) begin
      m_out  = d; m_dq = d; m_lq = l; m_mode = md;
      m_done = md && (d == l);
      m_run  = !m_done;
      m_wrap = 0;
    end else begin
      m_wrap = 0;
      if (m_run && e) begin
        if (m_out == m_lq) begin
          if (!m_mode) begin
            m_out  = m_dq;
            m_wrap = 1;
          end else begin
            m_run = 0; m_done = 1;
          end
        end else begin
          m_out = u ? (m_out + 1) % MOD : (m_out + MOD - 1) % MOD;
          if (m_mode && m_out == m_lq) begin
            m_run = 0; m_done = 1;
          end
        end
      end
    end
  endtask

  task automatic tick(input bit rst, input bit ld, input int d, input int l,
                      input bit md, input bit u, input bit e);
    logic [W-1:0] dv, lv;
    dv = d[W-1:0];
    lv = l[W-1:0];
    reset    = rst;
    bus.load = ld;
    bus.data = dv;
    bus.lmt  = lv;
    bus.mode = md;
    bus.up   = u;
    bus.en   = e;
    @(posedge clk);
    model_edge(rst, ld, int'(dv), int'(lv), md, u, e);
    #1;
  endtask

  always @(negedge clk) begin
    if (cmp_on) begin
      chk("out",  32'(bus.out),  32'(m_out));
      chk("tc",   32'(bus.tc),   32'((m_run || m_done) && (m_out == m_lq)));
      chk("wrap", 32'(bus.wrap), 32'(m_wrap));
      chk("done", 32'(bus.done), 32'(m_done));
      chk("busy", 32'(bus.busy), 32'(m_run));
    end
  end

  initial begin
    int seq_os [5];
    int seq_wr [6];
    int seq_dn [4];
    seq_os = '{3, 4, 5, 6, 7};
    seq_wr = '{2, 3, 4, 5, 2, 3};
    seq_dn = '{1, 0, 15, 14};

    tick(1, 0, 0, 0, 0, 0, 0);
    tick(1, 0, 0, 0, 0, 0, 0);
    cmp_on = 1'b1;
    chk("rst_out",  32'(bus.out),  32'd0);
    chk("rst_busy", 32'(bus.busy), 32'd0);
    chk("rst_done", 32'(bus.done), 32'd0);
    chk("rst_wrap", 32'(bus.wrap), 32'd0);

    // Idle ignores en.
    for (int i = 0; i < 5; i++) begin
      tick(0, 0, 0, 0, 0, 1, 1);
      chk("idle_out",  32'(bus.out),  32'd0);
      chk("idle_busy", 32'(bus.busy), 32'd0);
      chk("idle_tc",   32'(bus.tc),   32'd0);
    end

    // One-shot up 3 -> 7.
    tick(0, 1, 3, 7, 1, 1, 0);
    chk("os_load", 32'(bus.out), 32'd3);
    for (int i = 1; i < 5; i++) begin
      tick(0, 0, 0, 0, 0, 1, 1);
      chk("os_out",  32'(bus.out),  32'(seq_os[i]));
      chk("os_done", 32'(bus.done), 32'(i == 4));
      chk("os_tc",   32'(bus.tc),   32'(i == 4));
    end
    for (int i = 0; i < 2; i++) begin
      tick(0, 0, 0, 0, 0, 1, 1);
      chk("os_hold", 32'(bus.out), 32'd7);
    end

    // Wrap up 2 -> 5 -> 2; lmt/data changes after load must be ignored.
    tick(0, 1, 2, 5, 0, 1, 0);
    chk("wr_load", 32'(bus.out), 32'd2);
    for (int i = 1; i < 6; i++) begin
      tick(0, 0, 9, 12, 1, 1, 1);
      chk("wr_out",  32'(bus.out),  32'(seq_wr[i]));
      chk("wr_wrap", 32'(bus.wrap), 32'(i == 4));
    end

    // Down-count one-shot through natural roll-over.
    tick(0, 1, 1, 14, 1, 0, 0);
    chk("dn_load", 32'(bus.out), 32'd1);
    for (int i = 1; i < 4; i++) begin
      tick(0, 0, 0, 0, 0, 0, 1);
      chk("dn_out",  32'(bus.out),  32'(seq_dn[i]));
      chk("dn_wrap", 32'(bus.wrap), 32'd0);
      chk("dn_done", 32'(bus.done), 32'(i == 3));
    end

    // Load beats en; data == lmt in one-shot finishes immediately.
    tick(0, 1, 2, 12, 0, 1, 0);
    tick(0, 0, 0, 0, 0, 1, 1);
    tick(0, 1, 9, 12, 0, 1, 1);
    chk("ld_en_out",  32'(bus.out),  32'd9);
    chk("ld_en_busy", 32'(bus.busy), 32'd1);
    tick(0, 1, 4, 4, 1, 1, 0);
    chk("eq_out",  32'(bus.out),  32'd4);
    chk("eq_done", 32'(bus.done), 32'd1);
    chk("eq_tc",   32'(bus.tc),   32'd1);
    chk("eq_busy", 32'(bus.busy), 32'd0);

    // Reset mid-run (with a competing load), then clean restart.
    tick(0, 1, 0, 10, 1, 1, 0);
    for (int i = 0; i < 6; i++) tick(0, 0, 0, 0, 0, 1, 1);
    chk("mid_out", 32'(bus.out), 32'd6);
    tick(1, 1, 11, 13, 0, 1, 1);
    chk("mr_out",  32'(bus.out),  32'd0);
    chk("mr_busy", 32'(bus.busy), 32'd0);
    chk("mr_done", 32'(bus.done), 32'd0);
    chk("mr_tc",   32'(bus.tc),   32'd0);
    tick(0, 1, 5, 8, 1, 1, 0);
    tick(0, 0, 0, 0, 0, 1, 1);
    chk("rs_out",  32'(bus.out),  32'd6);
    chk("rs_busy", 32'(bus.busy), 32'd1);

    // Random run.
    for (int i = 0; i < 1500; i++) begin
      bit rr, rl, rm, ru, re;
      int rd, rlm;
      rr  = ($urandom_range(0, 59) == 0);
      rl  = ($urandom_range(0, 11) == 0);
      rm  = $urandom_range(0, 1);
      ru  = ($urandom_range(0, 7) != 0);
      re  = ($urandom_range(0, 3) != 0);
      rd  = $urandom_range(0, MOD - 1);
      rlm = ($urandom_range(0, 7) == 0) ? rd : $urandom_range(0, MOD - 1);
      tick(rr, rl, rd, rlm, rm, ru, re);
    end

    @(negedge clk);
    cmp_on = 1'b0;
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
